// File: rtl/rv_wb_pkg.sv
// rv_wb_pkg: shared types and constants for the write-back stage.
//   XLEN_DEF   - default datapath width
//   REG_ADDR_W - register-file address width
//   wb_entry_t - buffered MDU result {rd, data}
//   wb_src_e   - which producer commits in a given cycle
package rv_wb_pkg;
    localparam int XLEN_DEF   = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN_DEF-1:0]   data;
    } wb_entry_t;

    typedef enum logic [1:0] {
        WB_NONE,
        WB_ALU,
        WB_MDU
    } wb_src_e;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries.
//   clk, rst      - clock, synchronous active-high reset (pointers/count only)
//   push_i        - enqueue push_data_i (ignored when full)
//   push_data_i   - entry to enqueue
//   pop_i         - dequeue head (ignored when empty)
//   head_o        - current head entry
//   full_o        - count == DEPTH
//   empty_o       - count == 0
//   count_o       - number of valid entries
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter type entry_t = wb_entry_t,
    parameter int  DEPTH   = 2,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  entry_t           push_data_i,
    input  logic             pop_i,
    output entry_t           head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == DEPTH_C);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        // Simultaneous push and pop leaves the count unchanged.
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible through count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end
endmodule

// File: rtl/wb_stage.sv
// wb_stage: write-back stage, driving the register-file write port.
//   clk, rst                - clock, synchronous active-high reset
//   alu_valid/alu_ready     - single-cycle ALU/load/JAL result handshake
//   alu_rd, alu_data        - ALU destination and result
//   alu_jal, alu_link       - commit alu_link (PC+4) instead of alu_data
//   mdu_valid/mdu_ready     - MUL/DIV result handshake into the result FIFO
//   mdu_rd, mdu_data        - MDU destination and result
//   wr_en, rd_addr,
//   write_data              - registered register-file write port
//   rs1_addr, rs2_addr      - decode source registers for bypass compare
//   rs1_fwd, rs2_fwd        - source matches the in-flight write
// Build option: WB_BYPASS_EN enables the bypass compare; otherwise the
// fwd outputs are tied low and the rs addresses are ignored.
module wb_stage
    import rv_wb_pkg::*;
#(
    parameter int XLEN           = XLEN_DEF,
    parameter int MDU_FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    output logic                  alu_ready,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  alu_jal,
    input  logic [XLEN-1:0]       alu_link,
    input  logic                  mdu_valid,
    output logic                  mdu_ready,
    input  logic [REG_ADDR_W-1:0] mdu_rd,
    input  logic [XLEN-1:0]       mdu_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       write_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic                  rs1_fwd,
    output logic                  rs2_fwd
);
    localparam int CNT_W = $clog2(MDU_FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(MDU_FIFO_DEPTH);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } entry_t;

    entry_t                mdu_entry, fifo_head;
    logic                  fifo_empty, fifo_full_unused;
    logic [CNT_W-1:0]      fifo_count;
    logic                  accept, alu_fire, mdu_push, mdu_pop;
    wb_src_e               src;
    logic [REG_ADDR_W-1:0] commit_rd;
    logic [XLEN-1:0]       commit_data;

    logic                  wr_en_q;
    logic [REG_ADDR_W-1:0] rd_addr_q;
    logic [XLEN-1:0]       write_data_q;

    // Both producers stall on a full FIFO: blocking the ALU forces a drain
    // so buffered MDU results cannot starve behind a steady ALU stream.
    assign accept    = !rst && (fifo_count < DEPTH_C);
    assign alu_ready = accept;
    assign mdu_ready = accept;
    assign alu_fire  = alu_valid && accept;
    assign mdu_push  = mdu_valid && accept;
    assign mdu_entry = '{rd: mdu_rd, data: mdu_data};

    always_comb begin
        src = WB_NONE;
        if (rst)              src = WB_NONE;
        else if (alu_fire)    src = WB_ALU;
        else if (!fifo_empty) src = WB_MDU;
    end

    assign mdu_pop = (src == WB_MDU);

    always_comb begin
        commit_rd   = fifo_head.rd;
        commit_data = fifo_head.data;
        if (src == WB_ALU) begin
            commit_rd   = alu_rd;
            commit_data = alu_jal ? alu_link : alu_data;
        end
    end

    wb_fifo #(
        .entry_t (entry_t),
        .DEPTH   (MDU_FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (mdu_push),
        .push_data_i (mdu_entry),
        .pop_i       (mdu_pop),
        .head_o      (fifo_head),
        .full_o      (fifo_full_unused), // readiness is taken from count
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    // Commits to x0 still consume the source but never raise wr_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en_q      <= 1'b0;
            rd_addr_q    <= '0;
            write_data_q <= '0;
        end else begin
            wr_en_q <= (src != WB_NONE) && (commit_rd != '0);
            if (src != WB_NONE) begin
                rd_addr_q    <= commit_rd;
                write_data_q <= commit_data;
            end
        end
    end

    assign wr_en      = wr_en_q;
    assign rd_addr    = rd_addr_q;
    assign write_data = write_data_q;

`ifdef WB_BYPASS_EN
    assign rs1_fwd = wr_en_q && (rd_addr_q != '0) && (rd_addr_q == rs1_addr);
    assign rs2_fwd = wr_en_q && (rd_addr_q != '0) && (rd_addr_q == rs2_addr);
`else
    logic unused_rs;
    assign unused_rs = ^{rs1_addr, rs2_addr};
    assign rs1_fwd   = 1'b0;
    assign rs2_fwd   = 1'b0;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and random checks of wb_stage against a queue model.
module tb_wb_stage;
    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, alu_ready, alu_jal;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data, alu_link;
    logic        mdu_valid, mdu_ready;
    logic [4:0]  mdu_rd;
    logic [31:0] mdu_data;
    logic        wr_en;
    logic [4:0]  rd_addr;
    logic [31:0] write_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic        rs1_fwd, rs2_fwd;

    int checks = 0;
    int errors = 0;

    // Reference state: pending MDU results in order, and expected write port.
    logic [36:0] mq [$];
    logic        e_wr;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;

    always #5 clk = ~clk;

    wb_stage #(.XLEN(32), .MDU_FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .alu_data(alu_data), .alu_jal(alu_jal), .alu_link(alu_link),
        .mdu_valid(mdu_valid), .mdu_ready(mdu_ready), .mdu_rd(mdu_rd),
        .mdu_data(mdu_data),
        .wr_en(wr_en), .rd_addr(rd_addr), .write_data(write_data),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: check readiness mid-cycle, advance the model, check outputs.
    task automatic step();
        logic        rdy, c;
        logic [4:0]  crd;
        logic [31:0] cd;
        logic [36:0] ent;
        logic        f1, f2;
        @(negedge clk);
        rdy = !rst && (mq.size() < DEPTH);
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, rdy});
        chk("mdu_ready", {31'd0, mdu_ready}, {31'd0, rdy});
        c = 1'b0; crd = '0; cd = '0;
        if (rst) begin
            mq.delete();
            e_wr = 1'b0; e_rd = '0; e_wd = '0;
        end else begin
            if (alu_valid && rdy) begin
                c = 1'b1; crd = alu_rd; cd = alu_jal ? alu_link : alu_data;
            end else if (mq.size() > 0) begin
                ent = mq.pop_front();
                c = 1'b1; crd = ent[36:32]; cd = ent[31:0];
            end
            if (mdu_valid && rdy) mq.push_back({mdu_rd, mdu_data});
            e_wr = c && (crd != 0);
            if (c) begin e_rd = crd; e_wd = cd; end
        end
        @(posedge clk);
        #1;
        chk("wr_en", {31'd0, wr_en}, {31'd0, e_wr});
        chk("rd_addr", {27'd0, rd_addr}, {27'd0, e_rd});
        chk("write_data", write_data, e_wd);
`ifdef WB_BYPASS_EN
        f1 = e_wr && (e_rd == rs1_addr);
        f2 = e_wr && (e_rd == rs2_addr);
`else
        f1 = 1'b0;
        f2 = 1'b0;
`endif
        chk("rs1_fwd", {31'd0, rs1_fwd}, {31'd0, f1});
        chk("rs2_fwd", {31'd0, rs2_fwd}, {31'd0, f2});
    endtask

    initial begin
        rst = 1'b1;
        alu_valid = 0; alu_jal = 0; alu_rd = 0; alu_data = 0; alu_link = 0;
        mdu_valid = 0; mdu_rd = 0; mdu_data = 0;
        rs1_addr = 0; rs2_addr = 0;
        e_wr = 0; e_rd = 0; e_wd = 0;

        // Reset state
        step(); step();
        chk("reset_wr_en", {31'd0, wr_en}, 32'd0);
        chk("reset_wd", write_data, 32'd0);

        // ALU write with bypass of x6
        rst = 0;
        alu_valid = 1; alu_rd = 6; alu_data = 32'h0000_0313;
        rs1_addr = 6; rs2_addr = 0;
        step();
        chk("alu_wr_en", {31'd0, wr_en}, 32'd1);
        chk("alu_rd", {27'd0, rd_addr}, 32'd6);
        chk("alu_wd", write_data, 32'h0000_0313);
`ifdef WB_BYPASS_EN
        chk("byp_rs1", {31'd0, rs1_fwd}, 32'd1);
        chk("byp_rs2", {31'd0, rs2_fwd}, 32'd0);
`endif

        // JAL link
        alu_jal = 1; alu_rd = 1; alu_link = 32'h0000_0104; alu_data = 32'h0000_DEAD;
        step();
        chk("jal_wd", write_data, 32'h0000_0104);
        chk("jal_rd", {27'd0, rd_addr}, 32'd1);

        // x0 suppression: ALU then MDU
        alu_jal = 0; alu_rd = 0; alu_data = 32'hFFFF_FFFF;
        step();
        chk("x0_alu_wr_en", {31'd0, wr_en}, 32'd0);
        alu_valid = 0; mdu_valid = 1; mdu_rd = 0; mdu_data = 32'h55;
        step();
        mdu_valid = 0;
        step();
        chk("x0_mdu_wr_en", {31'd0, wr_en}, 32'd0);
        step();
        chk("x0_empty_ready", {31'd0, mdu_ready}, 32'd1);

        // Collision: ALU first, MDU next cycle
        alu_valid = 1; alu_rd = 5; alu_data = 32'h11;
        mdu_valid = 1; mdu_rd = 7; mdu_data = 32'h22;
        step();
        chk("col_alu_rd", {27'd0, rd_addr}, 32'd5);
        chk("col_alu_wd", write_data, 32'h11);
        alu_valid = 0; mdu_valid = 0;
        step();
        chk("col_mdu_rd", {27'd0, rd_addr}, 32'd7);
        chk("col_mdu_wd", write_data, 32'h22);

        // FIFO full and drain
        alu_valid = 1; alu_rd = 10; alu_data = 32'hA;
        mdu_valid = 1; mdu_rd = 8; mdu_data = 32'h88;
        step();
        mdu_rd = 9; mdu_data = 32'h99;
        step();
        mdu_valid = 0;
        step();
        chk("full_drain_rd8", {27'd0, rd_addr}, 32'd8);
        chk("full_drain_wd8", write_data, 32'h88);
        alu_valid = 0;
        step();
        chk("full_drain_rd9", {27'd0, rd_addr}, 32'd9);
        chk("full_drain_wd9", write_data, 32'h99);

        // Reset with FIFO full
        alu_valid = 1; alu_rd = 11; alu_data = 32'hB;
        mdu_valid = 1; mdu_rd = 8; mdu_data = 32'h88;
        step();
        mdu_rd = 9; mdu_data = 32'h99;
        step();
        rst = 1; alu_valid = 0; mdu_valid = 0;
        step();
        chk("rst_mid_wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst_mid_rd", {27'd0, rd_addr}, 32'd0);
        rst = 0;
        step();
        chk("rst_after_ready", {31'd0, mdu_ready}, 32'd1);
        chk("rst_after_wr_en", {31'd0, wr_en}, 32'd0);
        step();
        chk("rst_after_wr_en2", {31'd0, wr_en}, 32'd0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 59) == 0);
            alu_valid = $urandom_range(0, 1);
            alu_jal   = ($urandom_range(0, 3) == 0);
            alu_rd    = 5'($urandom_range(0, 31));
            alu_data  = $urandom;
            alu_link  = $urandom;
            mdu_valid = $urandom_range(0, 1);
            mdu_rd    = 5'($urandom_range(0, 31));
            mdu_data  = $urandom;
            rs1_addr  = ($urandom_range(0, 1) == 1) ? e_rd : 5'($urandom_range(0, 31));
            rs2_addr  = 5'($urandom_range(0, 31));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
